uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit path between `NUM_REQ` byte producers. It sits in front of the transmit controller: it accepts one byte at a time from the winning requester and launches it with a one-cycle start strobe. It then holds off further launches for one full frame time, because the transmit controller exposes no busy flag. A one-hot grant vector and a busy flag are provided for status and debug.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit (50 MHz / 115200). Must match the baud generator.
- `FRAME_BITS`, default 10: bits per frame (start + 8 data + stop).
- Derived: `FRAME_CYCLES = CLKS_PER_BIT*FRAME_BITS`. Counter width is `$clog2(FRAME_CYCLES)`.
- `clk`  in  1: single clock for the whole block.
- `reset`  in  1: asynchronous, active-low. 0 clears all state immediately, independent of `clk`.
- `i_req`  in  NUM_REQ: per-requester byte-pending flag. Must be held with its data until acked.
- `i_data`  in  8*NUM_REQ: byte for requester k at bits [8k+7:8k].
- `o_ack`  out  NUM_REQ: one-cycle, one-hot pulse; the byte of requester k was taken.
- `o_tx_data`  out  8: byte to the transmit controller. Stable for the entire frame.
- `o_tx_ready`  out  1: one-cycle start strobe to the transmit controller.
- `o_busy`  out  1: high while a frame is in flight.
- `o_grant`  out  NUM_REQ: one-hot index of the current or last launched requester. Held until the next grant.

## Operation
- FSM has three states: IDLE, SEND, WAIT.
- IDLE:
  - If `i_req` is nonzero, pick winner k by round-robin and go to SEND.
  - In the same clock edge, register `o_tx_data <= i_data[k]` and `o_grant <= onehot(k)`, and set ptr = k.
- Round-robin order:
  - Search starts at ptr+1 and proceeds upward modulo `NUM_REQ`, wrapping from `NUM_REQ-1` to 0.
  - The first asserted `i_req` wins.
  - ptr changes only on a grant.
- SEND (exactly one cycle):
  - `o_tx_ready`=1 and `o_ack[k]`=1.
  - Load the frame counter with `FRAME_CYCLES-1`.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - At counter==0, go to IDLE.
  - `i_req` is ignored in this state.
- `o_busy` = 1 in SEND and WAIT, 0 in IDLE.
- A requester that drops `i_req` before its ack is simply skipped; no byte is lost or duplicated.
- The requester drops `i_req` or presents its next byte in the cycle after ack. A re-raised request competes normally and is not favoured.
- Simultaneous requests: exactly one is acked per frame. The others wait at most `NUM_REQ-1` frames (fairness bound).
- Reset value of every output is 0. ptr resets to `NUM_REQ-1`, so requester 0 wins the first arbitration.
- Reset asserted mid-frame: the FSM returns to IDLE, the counter clears and outputs clear. No ack is issued for the in-flight byte. The bench must tolerate a truncated line frame.

## Timing
- Request visible in IDLE at cycle T: `o_tx_ready`/`o_ack` are high in cycle T+1 (latency 1). `o_tx_data` and `o_grant` are valid from T+1.
- `o_busy` is high for cycles S..S+FRAME_CYCLES, where S is the SEND cycle (FRAME_CYCLES+1 cycles total).
- Earliest next SEND is S+FRAME_CYCLES+2. Start-to-start spacing is therefore ≥ FRAME_CYCLES+2.
- `o_tx_data` never changes between S and the next SEND.
- `o_tx_ready` and `o_ack` are never high in any cycle other than SEND. At most one bit of `o_ack` is ever set.

## Test plan
- Reset behaviour: hold `reset`=0 for 3 cycles, then release with no request. All outputs stay 0 for 100 cycles.
- Single requester (`CLKS_PER_BIT`=4, FRAME_CYCLES=40): raise `i_req`=4'b0100 with byte 0xA5.
  - Ack/strobe one cycle later, `o_tx_data`=0xA5, `o_grant`=4'b0100.
  - `o_busy` high for exactly 41 cycles.
- Full contention: all four requesters hold `i_req` with bytes 0x10/0x21/0x32/0x43.
  - Launch order is 0x10, 0x21, 0x32, 0x43, 0x10…
  - Start strobes are exactly 42 cycles apart.
- Wrap-around: only requesters 3 and 1 request after the last grant was 3. Next grant is 1, then 3.
- Withdrawal: requester 2 drops `i_req` during WAIT while requester 0 still requests. Next grant is 0, and requester 2 receives no ack.
- Reset mid-operation: assert `reset` 10 cycles into a frame.
  - Outputs are 0 asynchronously, with no ack pulse.
  - After release, a pending request from requester 0 is launched first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of a UART transmit controller: takes one byte per frame
// from the winning requester, strobes it out, then blocks for a full frame time.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 434,
    parameter int FRAME_BITS   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_data,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_busy,
    output logic [NUM_REQ-1:0]   o_grant
);

    localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
    localparam int CW           = $clog2(FRAME_CYCLES);
    localparam int PW           = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic            win_vld;

    // Walk from the farthest offset down to ptr+1 so the nearest asserted request wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (i_req[(int'(ptr) + i) % NUM_REQ]) begin
                win     = PW'((int'(ptr) + i) % NUM_REQ);
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt       <= '0;
            ptr       <= PW'(NUM_REQ - 1);
            o_tx_data <= '0;
            o_grant   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_vld) begin
                ptr       <= win;
                o_tx_data <= i_data[int'(win)*8 +: 8];
                o_grant   <= NUM_REQ'(1) << win;
            end
            // Counter reaches zero on the last WAIT cycle and stays cleared while idle.
            if (state_q == SEND)
                cnt <= CW'(FRAME_CYCLES - 1);
            else if (state_q == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        o_tx_ready = 1'b0;
        o_ack      = '0;
        o_busy     = 1'b0;
        case (state_q)
            IDLE: if (win_vld) state_d = SEND;
            SEND: begin
                o_tx_ready = 1'b1;
                o_ack      = o_grant;
                o_busy     = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                o_busy = 1'b1;
                if (cnt == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
